// File: rtl/video_pkg.sv
// Shared constants and state type for the 1bpp framebuffer scan-out path.
package video_pkg;
    localparam int H_VISIBLE      = 640;
    localparam int V_VISIBLE      = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = H_VISIBLE / 16;
    localparam int ADDR_W         = 23;

    typedef enum logic {IDLE, REQ} fetch_state_e;
endpackage

// File: rtl/video_line_buffer.sv
// Ping-pong line store: two banks of WORDS x 16, one write port, one registered read port.
module video_line_buffer #(
    parameter int WORDS = 40,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          wr_bank_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [15:0]   wr_data_i,
    input  logic          rd_bank_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [15:0]   rd_data_o
);
    localparam int DEPTH = 2 * WORDS;
    localparam int AW    = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_addr, rd_addr;

    // bank 1 is stacked above bank 0, so the bank select is an offset add
    assign wr_addr = wr_bank_i ? AW'(WORDS) + AW'(wr_idx_i) : AW'(wr_idx_i);
    assign rd_addr = rd_bank_i ? AW'(WORDS) + AW'(rd_idx_i) : AW'(rd_idx_i);

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wr_addr] <= wr_data_i;
        rd_data_o <= mem_q[rd_addr];
    end
endmodule

// File: rtl/video_scanout.sv
// Fetches the next display line into a ping-pong buffer and streams 1bpp pixels
// with sync/visible realigned to the 2-cycle read pipeline.
module video_scanout
    import video_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              visible,
    input  logic [23:0]       fb_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    input  logic              underrun_clr,
    output logic              pixel_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              visible_out,
    output logic              underrun
);
    localparam int IW = $clog2(WORDS_PER_LINE);

    fetch_state_e      state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d, line_start_q, line_start_d, ls_next;
    logic              bank_q, bank_d, line0_q, line0_d;
    logic              primed_q, primed_d, underrun_q, underrun_d;
    logic              trig, tgt_vis, we;
    logic [15:0]       tgt;
    logic              unused_fb;

    assign unused_fb = fb_base[0];
    assign trig      = (x == 16'd0);
    assign tgt       = (y == 16'(V_TOTAL - 1)) ? 16'd0 : y + 16'd1;
    assign tgt_vis   = (tgt < 16'(V_VISIBLE));
    // line 0 reloads the base; every later line is a running sum
    assign ls_next   = (tgt == 16'd0) ? fb_base[23:1] : line_start_q + ADDR_W'(WORDS_PER_LINE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        line_start_d = line_start_q;
        bank_d       = bank_q;
        line0_d      = line0_q;
        primed_d     = primed_q;
        we           = 1'b0;
        underrun_d   = underrun_q & ~underrun_clr;
        if (trig) begin
            // a trigger always wins over a same-cycle ack
            if (state_q == REQ) underrun_d = 1'b1;
            if (tgt_vis) begin
                state_d      = REQ;
                idx_d        = '0;
                addr_d       = ls_next;
                line_start_d = ls_next;
                bank_d       = tgt[0];
                line0_d      = (tgt == 16'd0);
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == REQ && mem_ack) begin
            we     = 1'b1;
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + 1'b1;
            if (idx_q == IW'(WORDS_PER_LINE - 1)) begin
                state_d = IDLE;
                if (line0_q) primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            line_start_q <= '0;
            bank_q       <= 1'b0;
            line0_q      <= 1'b0;
            primed_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            line_start_q <= line_start_d;
            bank_q       <= bank_d;
            line0_q      <= line0_d;
            primed_q     <= primed_d;
            underrun_q   <= underrun_d;
        end
    end

    assign mem_req  = (state_q == REQ);
    assign mem_addr = addr_q;
    assign underrun = underrun_q;

    logic [11:0]   wsel;
    logic [IW-1:0] rd_idx;
    logic [15:0]   rd_data;
    logic [3:0]    bit_q;
    logic          vis1_q, hs1_q, vs1_q;
    logic          pix2_q, vis2_q, hs2_q, vs2_q;

    // clamp off-screen columns so the read never leaves the array
    assign wsel   = x[15:4];
    assign rd_idx = (wsel < 12'(WORDS_PER_LINE)) ? wsel[IW-1:0] : '0;

    video_line_buffer #(.WORDS(WORDS_PER_LINE), .IW(IW)) u_lbuf (
        .clk       (clk),
        .we_i      (we),
        .wr_bank_i (bank_q),
        .wr_idx_i  (idx_q),
        .wr_data_i (mem_data),
        .rd_bank_i (y[0]),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_q  <= '0;
            vis1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            pix2_q <= 1'b0;
            vis2_q <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
        end else begin
            bit_q  <= x[3:0];
            vis1_q <= visible;
            hs1_q  <= hsync;
            vs1_q  <= vsync;
            // MSB of each word is the leftmost pixel
            pix2_q <= rd_data[4'd15 - bit_q] & vis1_q & primed_q;
            vis2_q <= vis1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    assign pixel_out   = pix2_q;
    assign hsync_out   = hs2_q;
    assign vsync_out   = vs2_q;
    assign visible_out = vis2_q;
endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Downstream consumer of video_timing. Takes the raster position and sync signals and fetches a 1bpp framebuffer from main memory one line ahead of display.
- Uses a req/ack word handshake to memory and a ping-pong line buffer.
- Outputs a monochrome pixel stream plus sync/visible signals, delayed to stay aligned with the pixel.
- Sits between video_timing and the DAC/output pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line; must be a multiple of 16.
- V_VISIBLE, 480, visible lines per frame.
- V_TOTAL, 525, total lines per frame including vertical blanking.
- WORDS_PER_LINE, H_VISIBLE/16, 16-bit words fetched per line.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- x  in  16  current column from video_timing.
- y  in  16  current line from video_timing.
- hsync  in  1  from video_timing.
- vsync  in  1  from video_timing.
- visible  in  1  from video_timing.
- fb_base  in  24  framebuffer byte address; bit 0 ignored.
- mem_req  out  1  word read request.
- mem_addr  out  23  word address, i.e. byte address bits [23:1].
- mem_ack  in  1  read data valid this cycle.
- mem_data  in  16  read data.
- underrun_clr  in  1  clears the underrun flag.
- pixel_out  out  1  pixel value.
- hsync_out  out  1  hsync delayed 2 cycles.
- vsync_out  out  1  vsync delayed 2 cycles.
- visible_out  out  1  visible delayed 2 cycles.
- underrun  out  1  sticky fetch-late flag.

Behaviour:
- Reset (reset=0, async):
  - mem_req=0, mem_addr=0, pixel_out=0, all *_out=0, underrun=0, primed=0.
  - FSM goes to IDLE; line-buffer contents are don't-care.
- Fetch trigger:
  - Fires on the cycle x==0.
  - Target line is t = (y==V_TOTAL-1) ? 0 : y+1.
  - If t<V_VISIBLE, start fetching line t into bank t[0]. Otherwise no fetch.
- Line start address:
  - When t==0, line_start = fb_base[23:1]. fb_base is sampled only at this point.
  - Otherwise line_start = previous line_start + WORDS_PER_LINE.
  - No multiplier.
  - Word k of the line is at line_start+k, modulo 2^23.
- FSM:
  - IDLE --trigger with t visible--> REQ. On entry, word index=0 and mem_addr=line_start.
  - REQ: mem_req=1 and mem_addr held stable until mem_ack is sampled 1.
  - On ack: write mem_data into bank t[0] at the word index, then increment index and mem_addr.
  - After the last word (index WORDS_PER_LINE-1) is acked: mem_req=0, go to IDLE.
  - If that last word belongs to line 0, set primed=1.
  - mem_ack sampled while mem_req=0 is ignored.
  - At most one request is outstanding. mem_req may be reasserted the cycle after an ack.
- Underrun:
  - Applies when a trigger arrives while still in REQ.
  - Set underrun=1 and abandon the remaining words. The old bank keeps stale data.
  - Restart immediately for the new target line, or go to IDLE if the new target is not visible.
  - An ack on the same cycle as that trigger is dropped.
  - underrun_clr=1 clears the flag; an underrun event on the same cycle wins (flag stays 1).
- Display path (2-cycle latency):
  - Stage 1 registers bank y[0], word x[15:4], bit 15-x[3:0]. MSB is the leftmost pixel.
  - Stage 2 registers pixel_out = data bit & visible_d & primed.
  - hsync, vsync and visible pass through the same 2 flops.
  - Out-of-range x/y with visible=0 must not cause X propagation.
- Concurrency: the fetch writes bank t[0] while the display reads bank y[0]. These always differ because t=y+1, except at the frame wrap, where the last line is blank.

Decomposition:
- Package video_pkg:
  - Constants H_VISIBLE, V_VISIBLE, V_TOTAL, WORDS_PER_LINE, ADDR_W=23.
  - FSM state enum {IDLE, REQ}.
- Sub-module video_line_buffer:
  - Two banks of WORDS_PER_LINE x 16.
  - One write port (bank, index, data, we) and one registered read port (bank, index).
  - Inferable as block RAM.

Test Plan:
- Reset: hold reset=0 with toggling inputs -> mem_req=0, pixel_out=0, *_out=0, underrun=0. Release mid-line -> no request until the next x==0.
- Line-0 fetch: fb_base=0x100000, reach x==0 at y=524.
  - mem_addr sequence is 0x080000..0x080027, 40 requests.
  - With ack delayed 3 cycles, mem_addr is stable during each wait.
  - primed=1 after the 40th ack.
- Next lines: x==0 at y=0 -> fetch line 1 from 0x080028. x==0 at y=479..523 -> no mem_req.
- Pixel alignment:
  - Line 0 word 0 = 0x8001, word 1 = 0xFFFF.
  - At y=0, pixel_out at x=0, 15, and 16..31 is 1 (others in x<16 are 0), each appearing 2 cycles after that x.
  - hsync_out, vsync_out and visible_out equal the inputs delayed 2 cycles.
  - pixel_out=0 whenever visible_out=0.
- Underrun: withhold mem_ack for a whole line.
  - Next x==0 -> underrun=1 and mem_addr jumps to the next line start (+40).
  - Pulse underrun_clr -> 0.
  - Clear coincident with a new underrun -> stays 1.
- Reset mid-fetch: reset=0 while mem_req=1 at word 17 -> mem_req=0 asynchronously and primed=0. After release, no fetch until the next trigger.
